// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4:1 mux select scanner.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while en, wraps to 0 after the last cycle.
// Zero latency on `last`; clr has priority over en.
module mux_scan_dwell_cnt #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_select_scanner.sv
// Sweeps a 4:1 mux through all channels, samples y at the end of each dwell,
// publishes the word with a one-cycle done pulse. Optional: MUX_SCAN_CONT_EN.
module mux_select_scanner
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    state_t            state_q, state_d;
    ch_t               ch_q, ch_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dwell_last;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != ST_SCAN),
        .en   (state_q == ST_SCAN),
        .last (dwell_last)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (dwell_last) begin
                    shadow_d[ch_q] = y;
                    if (ch_q == ch_t'(NUM_CH - 1)) begin
                        // Publish including the bit captured at this same edge.
                        sample_d = shadow_d;
                        state_d  = ST_DONE;
                        ch_d     = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        ch_d = ch_q + ch_t'(1);
                    end
                end
            end
            ST_DONE: begin
`ifdef MUX_SCAN_CONT_EN
                if (start) begin
                    state_d = ST_SCAN;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign s1     = ch_q[0];
    assign s2     = ch_q[1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign sample = sample_q;

endmodule
